// File: rtl/fifo_byte_drain.sv
`default_nettype none
// ============================================================================
// Module   : fifo_byte_drain
// Purpose  : Pops 32-bit words from a 4-deep push/pop FIFO and streams each
//            one out as four bytes over a valid/ready byte interface.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_byte_drain #(
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 fifo_empty,
  input  logic [31:0]          fifo_data,
  output logic                 fifo_pop,
  output logic [7:0]           byte_out,
  output logic                 byte_valid,
  input  logic                 byte_ready,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] words_sent
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_POP  = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;

  localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]           r_state;
  logic [31:0]          r_word;
  logic [1:0]           r_idx;
  logic [CNT_WIDTH-1:0] r_words;
  logic [1:0]           w_lane;

  // Word launch, byte stepping and completed-word counting.
  // The head word is captured at the launching IDLE edge, so the FIFO
  // contents are irrelevant while the pop strobe is out.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_word  <= '0;
      r_idx   <= '0;
      r_words <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable && !fifo_empty) begin
            r_word  <= fifo_data;
            r_idx   <= 2'd0;
            r_state <= S_POP;
          end
        end
        S_POP: begin
          r_state <= S_SEND;
        end
        S_SEND: begin
          if (byte_ready) begin
            if (r_idx == 2'd3) begin
              r_words <= r_words + c_cnt_one;
              r_state <= S_IDLE;
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Map byte index to a byte lane of the held word according to send order.
  always_comb begin
    w_lane = MSB_FIRST ? (2'd3 - r_idx) : r_idx;
  end

  // Present the selected lane while sending; idle value is zero.
  always_comb begin
    byte_out = 8'h00;
    if (r_state == S_SEND) begin
      case (w_lane)
        2'd0:    byte_out = r_word[7:0];
        2'd1:    byte_out = r_word[15:8];
        2'd2:    byte_out = r_word[23:16];
        default: byte_out = r_word[31:24];
      endcase
    end
  end

  // Handshake and status strobes are pure state decodes.
  always_comb begin
    fifo_pop   = (r_state == S_POP);
    byte_valid = (r_state == S_SEND);
    busy       = (r_state != S_IDLE);
  end

  assign words_sent = r_words;

endmodule
`default_nettype wire

// File: tb/tb_fifo_byte_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_byte_drain
// Purpose  : Self-checking bench for fifo_byte_drain. Two instances (MSB and
//            LSB first) share all inputs; a queue models the FIFO and the
//            expected byte stream is derived from the pushed words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_byte_drain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [31:0] fifo_data = '0;
  logic        byte_ready = 1'b0;

  logic        pop0, pop1, v0, v1, busy0, busy1;
  logic [7:0]  b0, b1;
  logic [15:0] ws0, ws1;

  fifo_byte_drain #(.MSB_FIRST(1'b1), .CNT_WIDTH(16)) dut_msb (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_pop(pop0), .byte_out(b0), .byte_valid(v0),
    .byte_ready(byte_ready), .busy(busy0), .words_sent(ws0)
  );

  fifo_byte_drain #(.MSB_FIRST(1'b0), .CNT_WIDTH(16)) dut_lsb (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_pop(pop1), .byte_out(b1), .byte_valid(v1),
    .byte_ready(byte_ready), .busy(busy1), .words_sent(ws1)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          stall_err = 0;
  int          exp_words = 0;
  logic [31:0] fq[$];
  logic [7:0]  obs0[$];
  logic [7:0]  obs1[$];
  int          acc_cyc[$];
  int          pop_cyc[$];
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_b = '0;

  // Observer: records accepted bytes, pop strobes and stall stability,
  // and pops the FIFO model when the pop strobe is seen.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (v0 && byte_ready) begin
        obs0.push_back(b0);
        obs1.push_back(b1);
        acc_cyc.push_back(cyc);
      end
      if (prev_stall && (!v0 || b0 !== prev_b || !v1)) stall_err++;
      prev_stall = v0 && !byte_ready;
      prev_b = b0;
      if (pop0) begin
        pop_cyc.push_back(cyc);
        if (fq.size() > 0) void'(fq.pop_front());
      end
    end else begin
      prev_stall = 1'b0;
    end
    fifo_empty = (fq.size() == 0);
    fifo_data  = (fq.size() > 0) ? fq[0] : 32'h0;
  end

  // Reference byte for position k of word w in the given send order.
  function automatic logic [7:0] lane(input logic [31:0] w, input int k, input bit msb);
    return msb ? 8'(w >> (8 * (3 - k))) : 8'(w >> (8 * k));
  endfunction

  task automatic push(input logic [31:0] w);
    fq.push_back(w);
    fifo_empty = 1'b0;
    fifo_data  = fq[0];
  endtask

  task automatic clear_obs();
    obs0.delete();
    obs1.delete();
    acc_cyc.delete();
    pop_cyc.delete();
    stall_err = 0;
  endtask

  // Drive byte_ready per mode (0 always, 1 one-high/two-low, 2 random)
  // until the FIFO model is empty and the block is idle.
  task automatic drain(input int mode, input int max, output bit timeout);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      case (mode)
        0:       byte_ready = 1'b1;
        1:       byte_ready = (n % 3 == 0);
        default: byte_ready = 1'($urandom_range(0, 1));
      endcase
      n++;
    end while (!(fq.size() == 0 && !busy0) && n < max);
    timeout = (n >= max);
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; byte_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (pop0 !== 1'b0) begin n_fail++; $display("FAIL reset_pop got=%b exp=0", pop0); end
    n_checks++; if (v0 !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", v0); end
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy0); end
    n_checks++; if (b0 !== 8'h00) begin n_fail++; $display("FAIL reset_byte got=%h exp=00", b0); end
    n_checks++; if (ws0 !== 16'd0) begin n_fail++; $display("FAIL reset_words got=%0d exp=0", ws0); end
    @(posedge clk); #1;
    reset = 1'b0;
    exp_words = 0;
    clear_obs();
  endtask

  task automatic test_single_word();
    bit to;
    logic [31:0] w;
    w = 32'hDEADBEEF;
    clear_obs();
    push(w);
    enable = 1'b1;
    drain(0, 40, to);
    exp_words += 1;
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL single_timeout got=1 exp=0"); end
    n_checks++;
    if (obs0.size() != 4) begin
      n_fail++; $display("FAIL single_count got=%0d exp=4", obs0.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (obs0[k] !== lane(w, k, 1'b1)) begin n_fail++; $display("FAIL single_msb[%0d] got=%h exp=%h", k, obs0[k], lane(w, k, 1'b1)); end
        n_checks++;
        if (obs1[k] !== lane(w, k, 1'b0)) begin n_fail++; $display("FAIL single_lsb[%0d] got=%h exp=%h", k, obs1[k], lane(w, k, 1'b0)); end
      end
      n_checks++;
      if (acc_cyc[3] - acc_cyc[0] != 3) begin n_fail++; $display("FAIL single_consecutive got=%0d exp=3", acc_cyc[3] - acc_cyc[0]); end
    end
    n_checks++;
    if (pop_cyc.size() != 1) begin
      n_fail++; $display("FAIL single_pops got=%0d exp=1", pop_cyc.size());
    end else if (acc_cyc.size() > 0) begin
      n_checks++;
      if (acc_cyc[0] - pop_cyc[0] != 1) begin n_fail++; $display("FAIL single_latency got=%0d exp=1", acc_cyc[0] - pop_cyc[0]); end
    end
    n_checks++; if (ws0 !== 16'(exp_words)) begin n_fail++; $display("FAIL single_words got=%0d exp=%0d", ws0, exp_words); end
    n_checks++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL single_empty got=%b exp=1", fifo_empty); end
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL single_busy got=%b exp=0", busy0); end
  endtask

  task automatic test_back_to_back();
    bit to;
    logic [31:0] words [4];
    words = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'h0102030F};
    clear_obs();
    for (int i = 0; i < 4; i++) push(words[i]);
    enable = 1'b1;
    drain(0, 80, to);
    exp_words += 4;
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL b2b_timeout got=1 exp=0"); end
    n_checks++;
    if (obs0.size() != 16) begin
      n_fail++; $display("FAIL b2b_count got=%0d exp=16", obs0.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        n_checks++;
        if (obs0[i] !== lane(words[i/4], i % 4, 1'b1)) begin n_fail++; $display("FAIL b2b_byte[%0d] got=%h exp=%h", i, obs0[i], lane(words[i/4], i % 4, 1'b1)); end
      end
    end
    n_checks++;
    if (pop_cyc.size() != 4) begin
      n_fail++; $display("FAIL b2b_pops got=%0d exp=4", pop_cyc.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        n_checks++;
        if (pop_cyc[i] - pop_cyc[i-1] != 6) begin n_fail++; $display("FAIL b2b_spacing[%0d] got=%0d exp=6", i, pop_cyc[i] - pop_cyc[i-1]); end
      end
    end
    n_checks++; if (ws0 !== 16'(exp_words)) begin n_fail++; $display("FAIL b2b_words got=%0d exp=%0d", ws0, exp_words); end
  endtask

  task automatic test_stall(input int mode, input int nwords);
    bit to;
    logic [31:0] words[$];
    clear_obs();
    for (int i = 0; i < nwords; i++) begin
      words.push_back($urandom());
      push(words[i]);
    end
    enable = 1'b1;
    drain(mode, 400, to);
    exp_words += nwords;
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL stall%0d_timeout got=1 exp=0", mode); end
    n_checks++;
    if (obs0.size() != 4 * nwords) begin
      n_fail++; $display("FAIL stall%0d_count got=%0d exp=%0d", mode, obs0.size(), 4 * nwords);
    end else begin
      for (int i = 0; i < 4 * nwords; i++) begin
        n_checks++;
        if (obs0[i] !== lane(words[i/4], i % 4, 1'b1) || obs1[i] !== lane(words[i/4], i % 4, 1'b0)) begin
          n_fail++;
          $display("FAIL stall%0d_byte[%0d] got=%h/%h exp=%h/%h", mode, i, obs0[i], obs1[i],
                   lane(words[i/4], i % 4, 1'b1), lane(words[i/4], i % 4, 1'b0));
        end
      end
    end
    n_checks++; if (stall_err != 0) begin n_fail++; $display("FAIL stall%0d_hold got=%0d exp=0", mode, stall_err); end
    n_checks++; if (pop_cyc.size() != nwords) begin n_fail++; $display("FAIL stall%0d_pops got=%0d exp=%0d", mode, pop_cyc.size(), nwords); end
    n_checks++; if (ws0 !== 16'(exp_words)) begin n_fail++; $display("FAIL stall%0d_words got=%0d exp=%0d", mode, ws0, exp_words); end
  endtask

  task automatic test_enable();
    bit to;
    int n;
    logic [31:0] w1, w2;
    w1 = $urandom(); w2 = $urandom();
    clear_obs();
    enable = 1'b0;
    push(w1); push(w2);
    repeat (10) begin @(posedge clk); #1; byte_ready = 1'b1; end
    n_checks++; if (pop_cyc.size() != 0) begin n_fail++; $display("FAIL en_off_pops got=%0d exp=0", pop_cyc.size()); end
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL en_off_busy got=%b exp=0", busy0); end
    enable = 1'b1;
    n = 0;
    while (obs0.size() < 1 && n < 30) begin @(posedge clk); #1; n++; end
    n_checks++; if (n >= 30) begin n_fail++; $display("FAIL en_start_timeout got=%0d exp=<30", n); end
    enable = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    exp_words += 1;
    n_checks++;
    if (obs0.size() != 4) begin
      n_fail++; $display("FAIL en_drop_count got=%0d exp=4", obs0.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (obs0[k] !== lane(w1, k, 1'b1)) begin n_fail++; $display("FAIL en_drop_byte[%0d] got=%h exp=%h", k, obs0[k], lane(w1, k, 1'b1)); end
      end
    end
    n_checks++; if (pop_cyc.size() != 1) begin n_fail++; $display("FAIL en_drop_pops got=%0d exp=1", pop_cyc.size()); end
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL en_drop_busy got=%b exp=0", busy0); end
    n_checks++; if (fq.size() != 1) begin n_fail++; $display("FAIL en_drop_left got=%0d exp=1", fq.size()); end
    n_checks++; if (ws0 !== 16'(exp_words)) begin n_fail++; $display("FAIL en_drop_words got=%0d exp=%0d", ws0, exp_words); end
    clear_obs();
    enable = 1'b1;
    drain(0, 40, to);
    exp_words += 1;
    n_checks++; if (to !== 1'b0 || obs0.size() != 4) begin n_fail++; $display("FAIL en_resume got=%0d exp=4", obs0.size()); end
    n_checks++; if (ws0 !== 16'(exp_words)) begin n_fail++; $display("FAIL en_resume_words got=%0d exp=%0d", ws0, exp_words); end
  endtask

  task automatic test_reset_mid_word();
    bit to;
    int n;
    logic [31:0] w1, w2;
    w1 = $urandom(); w2 = $urandom();
    clear_obs();
    push(w1); push(w2);
    enable = 1'b1;
    n = 0;
    while (obs0.size() < 1 && n < 30) begin @(posedge clk); #1; byte_ready = 1'b1; n++; end
    n_checks++; if (n >= 30) begin n_fail++; $display("FAIL rst_mid_timeout got=%0d exp=<30", n); end
    byte_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (pop0 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pop got=%b exp=0", pop0); end
    n_checks++; if (v0 !== 1'b0 || v1 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got=%b%b exp=00", v0, v1); end
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got=%b exp=0", busy0); end
    n_checks++; if (b0 !== 8'h00 || b1 !== 8'h00) begin n_fail++; $display("FAIL rst_mid_byte got=%h/%h exp=00/00", b0, b1); end
    n_checks++; if (ws0 !== 16'd0) begin n_fail++; $display("FAIL rst_mid_words got=%0d exp=0", ws0); end
    exp_words = 0;
    clear_obs();
    drain(0, 40, to);
    exp_words += 1;
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL rst_after_timeout got=1 exp=0"); end
    n_checks++;
    if (obs0.size() != 4) begin
      n_fail++; $display("FAIL rst_after_count got=%0d exp=4", obs0.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (obs0[k] !== lane(w2, k, 1'b1)) begin n_fail++; $display("FAIL rst_after_byte[%0d] got=%h exp=%h", k, obs0[k], lane(w2, k, 1'b1)); end
      end
    end
    n_checks++; if (pop_cyc.size() != 1) begin n_fail++; $display("FAIL rst_after_pops got=%0d exp=1", pop_cyc.size()); end
    n_checks++; if (ws0 !== 16'(exp_words)) begin n_fail++; $display("FAIL rst_after_words got=%0d exp=%0d", ws0, exp_words); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_stall(1, 2);
    test_stall(2, 3);
    test_enable();
    test_reset_mid_word();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
